// File: rtl/cb_config_sequencer.sv
// Connection-block configuration sequencer: turns accepted config words into
// setup / enable-pulse / hold write cycles toward the block's address decoder.
`default_nettype none

module cb_config_sequencer #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 1,
  parameter int unsigned HOLD_CYC  = 1,
  parameter int unsigned NUM_MEMS  = 10
) (
  input  logic        prog_clk,
  input  logic        pReset_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [0:6]  cfg_addr,
  input  logic        cfg_data,
  input  logic        err_clr,
  output logic        enable,
  output logic [0:6]  address,
  output logic        data_in,
  output logic        busy,
  output logic        err,
  output logic [15:0] wr_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // Counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [7:0] SETUP_LD   = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PULSE_LD   = 8'(PULSE_CYC - 1);
  localparam logic [7:0] HOLD_LD    = 8'(HOLD_CYC - 1);
  localparam logic [4:0] NUM_MEMS_W = 5'(NUM_MEMS);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        enable_q, enable_d;
  logic [0:6]  addr_q, addr_d;
  logic        data_q, data_d;
  logic        err_q, err_d;
  logic [15:0] wr_count_q, wr_count_d;
  logic        init_q;
  logic        accept;
  logic        dec_ok;

  // init_q keeps the sequencer not-ready until the first edge after reset.
  assign cfg_ready = init_q && (state_q == IDLE);
  assign busy      = ~cfg_ready;
  assign accept    = cfg_valid && cfg_ready;
  assign dec_ok    = ({1'b0, cfg_addr[3:6]} < NUM_MEMS_W);

  assign enable    = enable_q;
  assign address   = addr_q;
  assign data_in   = data_q;
  assign err       = err_q;
  assign wr_count  = wr_count_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    err_d      = err_q;
    wr_count_d = wr_count_q;
    if (err_clr) err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (dec_ok) begin
            state_d = SETUP;
            cnt_d   = SETUP_LD;
            addr_d  = cfg_addr;
            data_d  = cfg_data;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = PULSE;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      PULSE: begin
        if (cnt_q == 8'd0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
          if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered strobe, decoded from the next state so it is a clean flop output.
    enable_d = (state_d == PULSE);
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      enable_q   <= 1'b0;
      addr_q     <= 7'b0;
      data_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_count_q <= 16'd0;
      init_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      enable_q   <= enable_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      err_q      <= err_d;
      wr_count_q <= wr_count_d;
      init_q     <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cb_config_sequencer.sv
// Directed self-checking bench for cb_config_sequencer (default and stretched timing).
`default_nettype none

module tb_cb_config_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;

  // Default-parameter instance
  logic        cfg_valid = 1'b0, cfg_data = 1'b0, err_clr = 1'b0;
  logic [0:6]  cfg_addr = 7'b0;
  logic        cfg_ready, enable, data_in, busy, err;
  logic [0:6]  address;
  logic [15:0] wr_count;

  // Stretched-timing instance
  logic        v2 = 1'b0, d2 = 1'b0, ec2 = 1'b0;
  logic [0:6]  a2 = 7'b0;
  logic        ready2, enable2, data2, busy2, err2;
  logic [0:6]  address2;
  logic [15:0] wr_count2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cb_config_sequencer dut (
    .prog_clk(clk), .pReset_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .err_clr(err_clr), .enable(enable),
    .address(address), .data_in(data_in), .busy(busy), .err(err), .wr_count(wr_count)
  );

  cb_config_sequencer #(.SETUP_CYC(3), .PULSE_CYC(2), .HOLD_CYC(4), .NUM_MEMS(10)) dut2 (
    .prog_clk(clk), .pReset_n(rst_n), .cfg_valid(v2), .cfg_ready(ready2),
    .cfg_addr(a2), .cfg_data(d2), .err_clr(ec2), .enable(enable2),
    .address(address2), .data_in(data2), .busy(busy2), .err(err2), .wr_count(wr_count2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", cfg_ready); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", busy); end
    n_checks++; if (enable !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %b expected 0", enable); end
    n_checks++; if (address !== 7'b0) begin n_fail++; $display("FAIL reset_address: got %b expected 0000000", address); end
    n_checks++; if (data_in !== 1'b0) begin n_fail++; $display("FAIL reset_data: got %b expected 0", data_in); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    n_checks++; if (wr_count !== 16'd0) begin n_fail++; $display("FAIL reset_wr_count: got %h expected 0000", wr_count); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %b expected 0", cfg_ready); end
    tick();
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_release: got %b expected 1", cfg_ready); end
  endtask

  task automatic test_single_write();
    cfg_valid = 1'b1; cfg_addr = 7'b0110101; cfg_data = 1'b1;
    tick();  // E0
    cfg_valid = 1'b0; cfg_addr = 7'b1111111; cfg_data = 1'b0;
    n_checks++; if (address !== 7'b0110101) begin n_fail++; $display("FAIL sw_address: got %b expected 0110101", address); end
    n_checks++; if (data_in !== 1'b1) begin n_fail++; $display("FAIL sw_data: got %b expected 1", data_in); end
    n_checks++; if (enable !== 1'b0) begin n_fail++; $display("FAIL sw_enable_e0: got %b expected 0", enable); end
    n_checks++; if (cfg_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL sw_busy_e0: got ready=%b busy=%b expected 0/1", cfg_ready, busy); end
    tick();  // E0+1
    n_checks++; if (enable !== 1'b1) begin n_fail++; $display("FAIL sw_enable_e1: got %b expected 1", enable); end
    tick();  // E0+2
    n_checks++; if (enable !== 1'b0) begin n_fail++; $display("FAIL sw_enable_e2: got %b expected 0", enable); end
    n_checks++; if (wr_count !== 16'd1) begin n_fail++; $display("FAIL sw_wr_count: got %h expected 0001", wr_count); end
    n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL sw_ready_e2: got %b expected 0", cfg_ready); end
    tick();  // E0+3
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL sw_ready_e3: got %b expected 1", cfg_ready); end
    tick();
    tick();
    n_checks++; if (address !== 7'b0110101 || data_in !== 1'b1) begin n_fail++; $display("FAIL sw_idle_hold: got %b/%b expected 0110101/1", address, data_in); end
  endtask

  task automatic test_back_to_back();
    int last;
    int t;
    logic [0:6] w;
    logic [0:6] prev;
    do_reset();
    last = 0;
    prev = 7'b0;
    cfg_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      w = {3'(i % 8), 4'(i)};
      cfg_addr = w;
      cfg_data = i[0];
      t = 0;
      while (!cfg_ready && t < 20) begin
        n_checks++; if (address !== prev) begin n_fail++; $display("FAIL b2b_addr_stable: got %b expected %b", address, prev); end
        tick();
        t++;
      end
      if (t >= 20) begin
        n_checks++; n_fail++;
        $display("FAIL b2b_timeout: ready=%b expected 1 within 20 cycles", cfg_ready);
      end
      tick();  // accept edge
      n_checks++; if (address !== w || data_in !== i[0]) begin n_fail++; $display("FAIL b2b_load: got %b/%b expected %b/%b", address, data_in, w, i[0]); end
      if (i > 0) begin
        n_checks++; if (cyc - last !== 4) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 4", cyc - last); end
      end
      last = cyc;
      prev = w;
    end
    cfg_valid = 1'b0;
    t = 0;
    while (!cfg_ready && t < 20) begin tick(); t++; end
    n_checks++; if (wr_count !== 16'd10) begin n_fail++; $display("FAIL b2b_wr_count: got %0d expected 10", wr_count); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %b expected 0", err); end
  endtask

  task automatic test_reject();
    logic [0:6] a0;
    logic [15:0] c0;
    a0 = address;
    c0 = wr_count;
    cfg_valid = 1'b1; cfg_addr = 7'b0001010; cfg_data = 1'b1;
    tick();
    cfg_valid = 1'b0;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL rej_err_set: got %b expected 1", err); end
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rej_ready: got %b expected 1", cfg_ready); end
    n_checks++; if (address !== a0) begin n_fail++; $display("FAIL rej_address: got %b expected %b", address, a0); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (enable !== 1'b0) begin n_fail++; $display("FAIL rej_enable: got %b expected 0 at cycle %0d", enable, k); end
      tick();
    end
    n_checks++; if (wr_count !== c0) begin n_fail++; $display("FAIL rej_wr_count: got %h expected %h", wr_count, c0); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rej_err_clr: got %b expected 0", err); end
    cfg_valid = 1'b1; cfg_addr = 7'b0001111; err_clr = 1'b1;
    tick();
    cfg_valid = 1'b0; err_clr = 1'b0;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL rej_set_wins: got %b expected 1", err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_timing();
    logic exp_en;
    logic exp_rdy;
    v2 = 1'b1; a2 = 7'b1010011; d2 = 1'b1;
    tick();  // E0
    v2 = 1'b0; a2 = 7'b0; d2 = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) tick();
      exp_en  = (k == 3 || k == 4);
      exp_rdy = (k >= 9);
      n_checks++; if (enable2 !== exp_en) begin n_fail++; $display("FAIL tim_enable: got %b expected %b at E0+%0d", enable2, exp_en, k); end
      n_checks++; if (ready2 !== exp_rdy) begin n_fail++; $display("FAIL tim_ready: got %b expected %b at E0+%0d", ready2, exp_rdy, k); end
      n_checks++; if (address2 !== 7'b1010011) begin n_fail++; $display("FAIL tim_address: got %b expected 1010011 at E0+%0d", address2, k); end
    end
    n_checks++; if (wr_count2 !== 16'd1) begin n_fail++; $display("FAIL tim_wr_count: got %0d expected 1", wr_count2); end
  endtask

  task automatic test_reset_in_pulse();
    do_reset();
    cfg_valid = 1'b1; cfg_addr = 7'b0000010; cfg_data = 1'b1;
    tick();  // E0
    cfg_valid = 1'b0;
    tick();  // E0+1
    n_checks++; if (enable !== 1'b1) begin n_fail++; $display("FAIL rip_enable_pre: got %b expected 1", enable); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (enable !== 1'b0) begin n_fail++; $display("FAIL rip_enable_async: got %b expected 0", enable); end
    n_checks++; if (wr_count !== 16'd0) begin n_fail++; $display("FAIL rip_wr_count: got %0d expected 0", wr_count); end
    n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL rip_ready_in_reset: got %b expected 0", cfg_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++; if (cfg_ready !== 1'b1 || enable !== 1'b0) begin n_fail++; $display("FAIL rip_after_release: got ready=%b enable=%b expected 1/0", cfg_ready, enable); end
    n_checks++; if (wr_count !== 16'd0) begin n_fail++; $display("FAIL rip_wr_count_after: got %0d expected 0", wr_count); end
  endtask

  task automatic test_saturate();
    force dut.wr_count_q = 16'hFFFE;
    #1;
    release dut.wr_count_q;
    #1;
    n_checks++; if (wr_count !== 16'hFFFE) begin n_fail++; $display("FAIL sat_preload: got %h expected fffe", wr_count); end
    for (int n = 0; n < 2; n++) begin
      cfg_valid = 1'b1; cfg_addr = 7'b0000001; cfg_data = 1'b0;
      tick();
      cfg_valid = 1'b0;
      tick();
      tick();
      tick();
      n_checks++; if (wr_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_wr_count: got %h expected ffff after write %0d", wr_count, n); end
      n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL sat_ready: got %b expected 1", cfg_ready); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_reject();
    test_timing();
    test_reset_in_pulse();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
